// File: rtl/foc_pkg.sv
// foc_pkg: types and Q2.15 constants shared by the FOC voltage path blocks.
package foc_pkg;
    localparam int IO_WIDTH_DEF = 18;
    localparam logic signed [IO_WIDTH_DEF-1:0] ONE_Q15 = 18'sh08000;
    localparam logic signed [IO_WIDTH_DEF-1:0] MOD_MAX_DEF = ONE_Q15;

    typedef enum logic [2:0] {
        IDLE,
        DIV_D,
        WAIT_D,
        DIV_Q,
        WAIT_Q
    } state_t;
endpackage

// File: rtl/sat_sym.sv
// sat_sym: clamps a signed value to the symmetric range [-MOD_MAX, MOD_MAX].
module sat_sym
    import foc_pkg::*;
#(
    parameter int IO_WIDTH = IO_WIDTH_DEF,
    parameter logic signed [IO_WIDTH-1:0] MOD_MAX = MOD_MAX_DEF
) (
    input  logic signed [IO_WIDTH-1:0] din,
    output logic signed [IO_WIDTH-1:0] dout
);
    assign dout = (din > MOD_MAX) ? MOD_MAX : (din < -MOD_MAX) ? -MOD_MAX : din;
endmodule

// File: rtl/vdc_norm_seq.sv
// vdc_norm_seq: divides vd and vq by vdc through two sequential CORDIC divisions,
// saturates the quotients and presents them as modulation indices md/mq.
module vdc_norm_seq
    import foc_pkg::*;
#(
    parameter int IO_WIDTH = IO_WIDTH_DEF,
    parameter logic signed [IO_WIDTH-1:0] MOD_MAX = MOD_MAX_DEF,
    parameter logic signed [IO_WIDTH-1:0] VDC_MIN = 18'sh00100,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       sys_clk_i,
    input  logic                       reset_i,
    input  logic                       valid_i,
    input  logic signed [IO_WIDTH-1:0] vd_i,
    input  logic signed [IO_WIDTH-1:0] vq_i,
    input  logic signed [IO_WIDTH-1:0] vdc_i,
    output logic                       ready_o,
    output logic                       cor_start_o,
    output logic signed [IO_WIDTH-1:0] cor_x_o,
    output logic signed [IO_WIDTH-1:0] cor_y_o,
    output logic signed [IO_WIDTH-1:0] cor_theta_o,
    input  logic                       cor_done_i,
    input  logic signed [IO_WIDTH-1:0] cor_theta_i,
    output logic                       valid_o,
    output logic signed [IO_WIDTH-1:0] md_o,
    output logic signed [IO_WIDTH-1:0] mq_o,
    output logic                       err_o,
    output logic                       overrun_o
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic signed [IO_WIDTH-1:0] vq_r, qd, md_sat, mq_sat, md_d, mq_d, x_d, y_d;
    logic in_wait, accept, low_vdc, tmo, fault, start_d, valid_d;

    assign ready_o     = state == IDLE;
    assign cor_theta_o = '0;
    assign in_wait     = (state == WAIT_D) || (state == WAIT_Q);
    assign accept      = valid_i && ready_o;
    assign low_vdc     = vdc_i < VDC_MIN;
    // A done arriving on the last allowed cycle still wins over the timeout.
    assign tmo         = in_wait && !cor_done_i && (cnt == CW'(TIMEOUT_CYC - 1));
    assign fault       = tmo || (accept && low_vdc);

    sat_sym #(.IO_WIDTH(IO_WIDTH), .MOD_MAX(MOD_MAX)) u_sat_d (.din(qd), .dout(md_sat));
    sat_sym #(.IO_WIDTH(IO_WIDTH), .MOD_MAX(MOD_MAX)) u_sat_q (.din(cor_theta_i), .dout(mq_sat));

    always_ff @(posedge sys_clk_i or negedge reset_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = (valid_i && !low_vdc) ? DIV_D : IDLE;
            DIV_D:   state_nx = WAIT_D;
            WAIT_D:  state_nx = cor_done_i ? DIV_Q : tmo ? IDLE : WAIT_D;
            DIV_Q:   state_nx = WAIT_Q;
            WAIT_Q:  state_nx = (cor_done_i || tmo) ? IDLE : WAIT_Q;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start_d = (state_nx == DIV_D) || (state_nx == DIV_Q);
        valid_d = fault || ((state == WAIT_Q) && cor_done_i);
        md_d    = fault ? '0 : valid_d ? md_sat : md_o;
        mq_d    = fault ? '0 : valid_d ? mq_sat : mq_o;
        x_d     = accept ? vdc_i : cor_x_o;
        y_d     = accept ? vd_i : ((state == WAIT_D) && cor_done_i) ? vq_r : cor_y_o;
    end

    always_ff @(posedge sys_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cor_start_o <= 1'b0;
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            md_o        <= '0;
            mq_o        <= '0;
            cor_x_o     <= '0;
            cor_y_o     <= '0;
            overrun_o   <= 1'b0;
        end else begin
            cor_start_o <= start_d;
            valid_o     <= valid_d;
            err_o       <= fault;
            md_o        <= md_d;
            mq_o        <= mq_d;
            cor_x_o     <= x_d;
            cor_y_o     <= y_d;
            overrun_o   <= overrun_o | (valid_i && !ready_o);
        end
    end

    always_ff @(posedge sys_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            vq_r <= '0;
            qd   <= '0;
            cnt  <= '0;
        end else begin
            vq_r <= accept ? vq_i : vq_r;
            qd   <= ((state == WAIT_D) && cor_done_i) ? cor_theta_i : qd;
            cnt  <= ((state == DIV_D) || (state == DIV_Q)) ? '0 : in_wait ? cnt + 1'b1 : cnt;
        end
    end
endmodule
